// File: rtl/mem_arbiter.sv
// Two-port (I-cache / D-cache) arbiter in front of a single main-memory controller.
// Optional macro ROUND_ROBIN_EN: alternate grants on simultaneous requests instead of D-priority.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_access,
    input  logic          i_write,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_din,
    output logic [DW-1:0] i_dout,
    output logic          i_busy,
    output logic          i_start_read,
    input  logic          d_access,
    input  logic          d_write,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_din,
    output logic [DW-1:0] d_dout,
    output logic          d_busy,
    output logic          d_start_read,
    output logic          mem_access,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    input  logic          mem_busy,
    input  logic          mem_start_read,
    output logic          owner,
    output logic          timeout_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RECOVER} state_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_nxt;
    logic       owner_nxt;
    logic       last_owner, last_owner_nxt;
    logic [7:0] wdog, wdog_nxt;
    logic       timeout_err_nxt;
    logic       winner;
    logic       own_access;
    logic       in_txn;

    always_comb begin
`ifdef ROUND_ROBIN_EN
        winner = (i_access & d_access) ? ~last_owner : d_access;
`else
        winner = d_access;
`endif
    end

    assign own_access = owner ? d_access : i_access;
    assign in_txn     = (state == ISSUE) || (state == BUSY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_owner  <= 1'b0;
            wdog        <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            last_owner  <= last_owner_nxt;
            wdog        <= wdog_nxt;
            timeout_err <= timeout_err_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        owner_nxt       = owner;
        last_owner_nxt  = last_owner;
        wdog_nxt        = wdog;
        timeout_err_nxt = timeout_err;
        case (state)
            IDLE: begin
                if (i_access | d_access) begin
                    owner_nxt = winner;
                    wdog_nxt  = '0;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                wdog_nxt = wdog + 8'd1;
                if (!own_access) begin
                    state_nxt = RECOVER;
                end else if (wdog == WD_LAST) begin
                    state_nxt       = RECOVER;
                    timeout_err_nxt = 1'b1;
                end else if (mem_busy) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                wdog_nxt = wdog + 8'd1;
                if (!own_access) begin
                    state_nxt = RECOVER;
                end else if (!mem_busy) begin
                    // Completion wins over a watchdog expiring in the same cycle.
                    state_nxt      = RECOVER;
                    last_owner_nxt = owner;
                end else if (wdog == WD_LAST) begin
                    state_nxt       = RECOVER;
                    timeout_err_nxt = 1'b1;
                end
            end
            RECOVER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Controller side: idle values are zero so the controller never sees stale requests.
    assign mem_access = in_txn;
    assign mem_write  = in_txn & (owner ? d_write : i_write);
    assign mem_addr   = in_txn ? (owner ? d_addr : i_addr) : '0;
    assign mem_din    = in_txn ? (owner ? d_din  : i_din)  : '0;

    assign i_busy = i_access & ~(~owner & (state == RECOVER));
    assign d_busy = d_access & ~( owner & (state == RECOVER));

    assign i_start_read = mem_start_read & ~owner & in_txn;
    assign d_start_read = mem_start_read &  owner & in_txn;

    assign i_dout = mem_dout;
    assign d_dout = mem_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a small behavioural memory controller
// (6-cycle busy window, 4 read words flagged by mem_start_read, write committed at the end).
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_access, i_write, d_access, d_write;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [DW-1:0] i_din, d_din, i_dout, d_dout, mem_din, mem_dout;
    logic          i_busy, i_start_read, d_busy, d_start_read;
    logic          mem_access, mem_write, mem_busy, mem_start_read;
    logic          owner, timeout_err;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .i_access(i_access), .i_write(i_write), .i_addr(i_addr), .i_din(i_din),
        .i_dout(i_dout), .i_busy(i_busy), .i_start_read(i_start_read),
        .d_access(d_access), .d_write(d_write), .d_addr(d_addr), .d_din(d_din),
        .d_dout(d_dout), .d_busy(d_busy), .d_start_read(d_start_read),
        .mem_access(mem_access), .mem_write(mem_write), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_busy(mem_busy), .mem_start_read(mem_start_read),
        .owner(owner), .timeout_err(timeout_err)
    );

    // Controller model: word memory preloaded with 0x1000_0000 + word index on reset.
    logic [31:0] mem [0:255];
    logic        cbusy, cwr, wait_low, stuck;
    logic [2:0]  cnt;
    logic [7:0]  cidx;
    logic [31:0] cdin;

    always @(posedge clk) begin
        if (reset) begin
            cbusy    <= 1'b0;
            cnt      <= '0;
            wait_low <= 1'b0;
            cwr      <= 1'b0;
            cidx     <= '0;
            for (int k = 0; k < 256; k++) mem[k] <= 32'h1000_0000 + k;
        end else if (cbusy) begin
            cnt <= cnt + 3'd1;
            if (cnt == 3'd5) begin
                cbusy    <= 1'b0;
                wait_low <= 1'b1;
                if (cwr) mem[cidx] <= cdin;
            end
        end else if (wait_low) begin
            if (!mem_access) wait_low <= 1'b0;
        end else if (mem_access && !stuck) begin
            cbusy <= 1'b1;
            cnt   <= '0;
            cwr   <= mem_write;
            cidx  <= mem_addr[9:2];
            cdin  <= mem_din;
        end
    end

    assign mem_busy       = cbusy | stuck;
    assign mem_start_read = cbusy & ~cwr & (cnt >= 3'd1) & (cnt <= 3'd4);
    assign mem_dout       = mem[cidx + 8'(cnt) - 8'd1];

    // Scoreboard
    typedef struct {
        int          kind;   // 0 grant, 1 read word, 2 completion
        int          port;   // 0 = I, 1 = D
        logic [31:0] val;
    } ev_t;

    ev_t expq[$];
    int  n_pass = 0;
    int  n_fail = 0;
    int  busy_cnt = 0;
    int  acc_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input int kind, input int port, input logic [31:0] val);
        ev_t e;
        e.kind = kind; e.port = port; e.val = val;
        expq.push_back(e);
    endtask

    task automatic push_read(input int port, input logic [31:0] addr, input logic [31:0] w0);
        push_ev(0, port, addr);
        for (int k = 0; k < 4; k++) push_ev(1, port, w0 + k);
        push_ev(2, port, 0);
    endtask

    task automatic got_ev(input string name, input int kind, input int port, input logic [31:0] val);
        ev_t e;
        if (expq.size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected event port=%0d val=%0h, nothing expected", name, port, val);
        end else begin
            e = expq.pop_front();
            check({name, " kind"}, kind, e.kind);
            check({name, " port"}, port, e.port);
            check({name, " val"}, val, e.val);
        end
    endtask

    // Monitor: sampled on the falling edge, decoupled from stimulus.
    initial begin
        int  lowrun;
        logic acc_q;
        lowrun = 99;
        acc_q  = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                lowrun = 99;
                acc_q  = 1'b0;
                continue;
            end
            if (mem_access && !acc_q) begin
                check("idle_gap", lowrun >= 2, 1);
                got_ev("grant", 0, int'(owner), mem_addr);
            end
            if (mem_access) lowrun = 0;
            else if (lowrun < 99) lowrun++;
            acc_q = mem_access;
            if (i_start_read && d_start_read) begin
                n_fail++;
                $display("FAIL start_read: both ports high at once");
            end
            if (i_start_read) got_ev("i_data", 1, 0, i_dout);
            if (d_start_read) got_ev("d_data", 1, 1, d_dout);
            if (i_access && !i_busy) got_ev("i_done", 2, 0, 0);
            if (d_access && !d_busy) got_ev("d_done", 2, 1, 0);
            if (mem_busy) busy_cnt++;
            if (mem_access) acc_cnt++;
        end
    end

    // Stimulus helpers: drive at posedge+1, observe at negedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int port, input logic acc, input logic wr,
                           input logic [31:0] a, input logic [31:0] dn);
        if (port == 0) begin
            i_access = acc; i_write = wr; i_addr = a; i_din = dn;
        end else begin
            d_access = acc; d_write = wr; d_addr = a; d_din = dn;
        end
    endtask

    task automatic wait_done(input int port, input string name);
        bit ok = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if ((port == 0) ? !i_busy : !d_busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: busy never dropped within 80 cycles", name);
        end
    endtask

    task automatic txn(input int port, input logic wr, input logic [31:0] a, input logic [31:0] dn);
        set_req(port, 1'b1, wr, a, dn);
        wait_done(port, (port == 0) ? "i_txn" : "d_txn");
        tick();
        set_req(port, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int done_n;
        bit seen;
        reset = 1'b1;
        stuck = 1'b0;
        set_req(0, 1'b0, 1'b0, 0, 0);
        set_req(1, 1'b0, 1'b0, 0, 0);
        tick();
        @(negedge clk);
        check("rst_mem_access", mem_access, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_owner", owner, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_busy", {i_busy, d_busy, i_start_read, d_start_read}, 0);
        tick();
        reset = 1'b0;
        tick();

        // I read 0x40: one-cycle grant latency, 6 busy cycles, 4 words.
        push_read(0, 32'h40, 32'h1000_0010);
        busy_cnt = 0;
        set_req(0, 1'b1, 1'b0, 32'h40, 0);
        @(negedge clk);
        check("grant_lat_before", mem_access, 0);
        @(negedge clk);
        check("grant_lat_after", mem_access, 1);
        wait_done(0, "i_read_40");
        check("i_read_busy_cycles", busy_cnt, 6);
        tick();
        set_req(0, 1'b0, 1'b0, 0, 0);
        tick();

        // D write then D readback of the same line.
        push_ev(0, 1, 32'h100);
        push_ev(2, 1, 0);
        set_req(1, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF);
        @(negedge clk);
        @(negedge clk);
        check("d_write_mem_write", mem_write, 1);
        check("d_write_mem_din", mem_din, 32'hDEAD_BEEF);
        wait_done(1, "d_write_100");
        check("d_write_i_busy", i_busy, 0);
        tick();
        set_req(1, 1'b0, 1'b0, 0, 0);
        tick();
        push_ev(0, 1, 32'h100);
        push_ev(1, 1, 32'hDEAD_BEEF);
        push_ev(1, 1, 32'h1000_0041);
        push_ev(1, 1, 32'h1000_0042);
        push_ev(1, 1, 32'h1000_0043);
        push_ev(2, 1, 0);
        txn(1, 1'b0, 32'h100, 0);
        tick();

        // Simultaneous requests; last completed owner was D.
`ifdef ROUND_ROBIN_EN
        push_read(0, 32'h80, 32'h1000_0020);
        push_read(1, 32'hC0, 32'h1000_0030);
`else
        push_read(1, 32'hC0, 32'h1000_0030);
        push_read(0, 32'h80, 32'h1000_0020);
`endif
        fork
            txn(1, 1'b0, 32'hC0, 0);
            txn(0, 1'b0, 32'h80, 0);
        join
        tick();

        // Both held for four transactions from a fresh reset.
        do_reset();
`ifdef ROUND_ROBIN_EN
        push_read(1, 32'hC0, 32'h1000_0030);
        push_read(0, 32'h80, 32'h1000_0020);
        push_read(1, 32'hC0, 32'h1000_0030);
        push_read(0, 32'h80, 32'h1000_0020);
`else
        for (int k = 0; k < 4; k++) push_read(1, 32'hC0, 32'h1000_0030);
`endif
        set_req(0, 1'b1, 1'b0, 32'h80, 0);
        set_req(1, 1'b1, 1'b0, 32'hC0, 0);
        done_n = 0;
        for (int k = 0; k < 120 && done_n < 4; k++) begin
            @(negedge clk);
            if ((i_access && !i_busy) || (d_access && !d_busy)) done_n++;
        end
        check("held_txn_count", done_n, 4);
        tick();
        set_req(0, 1'b0, 1'b0, 0, 0);
        set_req(1, 1'b0, 1'b0, 0, 0);
        tick();

        // Watchdog: controller stuck busy.
        do_reset();
        check("wd_err_clear", timeout_err, 0);
        stuck = 1'b1;
        acc_cnt = 0;
        push_ev(0, 1, 32'h200);
        push_ev(2, 1, 0);
        set_req(1, 1'b1, 1'b0, 32'h200, 0);
        wait_done(1, "wd_release");
        check("wd_timeout_err", timeout_err, 1);
        check("wd_access_cycles", acc_cnt, 15);
        check("wd_owner", owner, 1);
        tick();
        set_req(1, 1'b0, 1'b0, 0, 0);
        stuck = 1'b0;
        tick();
        tick();
        check("wd_err_sticky", timeout_err, 1);

        // Reset mid-BUSY of a D read, then a clean I read.
        do_reset();
        tick();
        push_ev(0, 1, 32'h40);
        set_req(1, 1'b1, 1'b0, 32'h40, 0);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_busy) begin
                seen = 1;
                break;
            end
        end
        check("rst_mid_busy_seen", seen, 1);
        tick();
        check("rst_mid_pre_access", mem_access, 1);
        reset = 1'b1;
        set_req(1, 1'b0, 1'b0, 0, 0);
        #1;
        check("rst_mid_access_async", mem_access, 0);
        @(negedge clk);
        check("rst_mid_start_read", d_start_read, 0);
        tick();
        reset = 1'b0;
        tick();
        push_read(0, 32'h40, 32'h1000_0010);
        txn(0, 1'b0, 32'h40, 0);
        tick();
        tick();

        check("scoreboard_drained", expq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
